// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester-side byte handshake bundle for uart_tx_sched
interface uart_tx_sched_if;
    logic [1:0] req_valid;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [1:0] req_ready;

    modport master (output req_valid, output req_data0, output req_data1, input req_ready);
    modport slave  (input req_valid, input req_data0, input req_data1, output req_ready);
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-requester round-robin UART framer driving tx_clk_gen
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_sched #(
    parameter int STOP_BITS   = 1,
    parameter int TIMEOUT_CYC = 65535,
    parameter int TO_WD       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_sched_if.slave req,
    input  logic           bps_clk,
    output logic           tx_start,
    output logic           tx_done,
    output logic           txd,
    output logic           busy,
    output logic           gnt_id,
    output logic           err_timeout
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PAR,
`endif
        S_STOP,
        S_END
    } state_t;

    localparam logic [TO_WD-1:0] WD_LAST = TO_WD'(TIMEOUT_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       data_q;
    logic [2:0]       bit_idx;
    logic             stop_cnt;
    logic [TO_WD-1:0] wd_cnt;
    logic             last_gnt;
    logic             grant;
    logic             gnt_sel;
    logic             wd_hit;
    logic             stop_last;

    logic             txd_nxt;
    logic             tx_start_nxt;
    logic             tx_done_nxt;
    logic             busy_nxt;
    logic             err_nxt;
    logic [1:0]       ready_nxt;

    // With both requesters valid, the one not served last wins.
    always_comb begin
        grant = (state == S_IDLE) && (req.req_valid != 2'b00);
        case (req.req_valid)
            2'b01:   gnt_sel = 1'b0;
            2'b10:   gnt_sel = 1'b1;
            default: gnt_sel = ~last_gnt;
        endcase
    end

    // Abort fires on the cycle the counter would reach TIMEOUT_CYC without a baud pulse.
    assign wd_hit    = (state != S_IDLE) && (state != S_END) && !bps_clk && (wd_cnt == WD_LAST);
    assign stop_last = (STOP_BITS == 1) || stop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (wd_hit) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (grant) state_nxt = S_WAIT;
                S_WAIT:  if (bps_clk) state_nxt = S_START;
                S_START: if (bps_clk) state_nxt = S_DATA;
`ifdef UART_TX_PARITY_EN
                S_DATA:  if (bps_clk && bit_idx == 3'd7) state_nxt = S_PAR;
                S_PAR:   if (bps_clk) state_nxt = S_STOP;
`else
                S_DATA:  if (bps_clk && bit_idx == 3'd7) state_nxt = S_STOP;
`endif
                S_STOP:  if (bps_clk && stop_last) state_nxt = S_END;
                S_END:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        txd_nxt      = txd;
        tx_start_nxt = grant;
        ready_nxt    = grant ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
        tx_done_nxt  = wd_hit || ((state == S_STOP) && (state_nxt == S_END));
        err_nxt      = wd_hit;
        busy_nxt     = (state_nxt != S_IDLE) && (state_nxt != S_END);
        if (wd_hit) begin
            txd_nxt = 1'b1;
        end else if (bps_clk) begin
            case (state)
                S_WAIT:  txd_nxt = 1'b0;
                S_START: txd_nxt = data_q[0];
`ifdef UART_TX_PARITY_EN
                S_DATA:  txd_nxt = (bit_idx == 3'd7) ? ^data_q : data_q[bit_idx + 3'd1];
`else
                S_DATA:  txd_nxt = (bit_idx == 3'd7) ? 1'b1 : data_q[bit_idx + 3'd1];
`endif
                default: txd_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd           <= 1'b1;
            tx_start      <= 1'b0;
            tx_done       <= 1'b0;
            busy          <= 1'b0;
            err_timeout   <= 1'b0;
            req.req_ready <= 2'b00;
        end else begin
            txd           <= txd_nxt;
            tx_start      <= tx_start_nxt;
            tx_done       <= tx_done_nxt;
            busy          <= busy_nxt;
            err_timeout   <= err_nxt;
            req.req_ready <= ready_nxt;
        end
    end

    // last_gnt resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= 8'h00;
            gnt_id   <= 1'b0;
            last_gnt <= 1'b1;
            bit_idx  <= 3'd0;
            stop_cnt <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            if (grant) begin
                data_q   <= gnt_sel ? req.req_data1 : req.req_data0;
                gnt_id   <= gnt_sel;
                last_gnt <= gnt_sel;
            end
            if (state == S_START) begin
                bit_idx <= 3'd0;
            end else if (state == S_DATA && bps_clk) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (state != S_STOP) begin
                stop_cnt <= 1'b0;
            end else if (bps_clk) begin
                stop_cnt <= 1'b1;
            end
            if (state == S_IDLE || bps_clk) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + TO_WD'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - randomized/directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;
    localparam int PERIOD = 10;
    localparam int TOC    = 50;

    logic clk = 1'b0;
    logic rst_n;
    logic bps_clk;
    wire [1:0] tx_start;
    wire [1:0] tx_done;
    wire [1:0] txd;
    wire [1:0] busy;
    wire [1:0] gnt_id;
    wire [1:0] err_timeout;

    uart_tx_sched_if rif0 ();
    uart_tx_sched_if rif1 ();

    uart_tx_sched #(.STOP_BITS(1), .TIMEOUT_CYC(TOC), .TO_WD(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(rif0.slave), .bps_clk(bps_clk),
        .tx_start(tx_start[0]), .tx_done(tx_done[0]), .txd(txd[0]),
        .busy(busy[0]), .gnt_id(gnt_id[0]), .err_timeout(err_timeout[0])
    );

    uart_tx_sched #(.STOP_BITS(2), .TIMEOUT_CYC(TOC), .TO_WD(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(rif1.slave), .bps_clk(bps_clk),
        .tx_start(tx_start[1]), .tx_done(tx_done[1]), .txd(txd[1]),
        .busy(busy[1]), .gnt_id(gnt_id[1]), .err_timeout(err_timeout[1])
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    logic sel;
    bit   bps_en;
    int   bps_cnt;
    logic bps_prev;
    int   last_gnt[2];

    logic       s_txd, s_busy, s_start, s_done, s_gnt, s_err;
    logic [1:0] s_ready;

    always_comb begin
        s_txd   = txd[sel];
        s_busy  = busy[sel];
        s_start = tx_start[sel];
        s_done  = tx_done[sel];
        s_gnt   = gnt_id[sel];
        s_err   = err_timeout[sel];
        s_ready = sel ? rif1.req_ready : rif0.req_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (dut%0d): observed %0d expected %0d", tag, sel, obs, exp);
        end
    endtask

    // One cycle: sample on the falling edge, then schedule the baud pulse for the next rising edge.
    task automatic tick();
        @(negedge clk);
        bps_prev = bps_clk;
        bps_cnt  = (bps_cnt + 1) % PERIOD;
        bps_clk  = bps_en && (bps_cnt == PERIOD - 1);
    endtask

    task automatic set_req(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
        if (sel) begin
            rif1.req_valid = v; rif1.req_data0 = d0; rif1.req_data1 = d1;
        end else begin
            rif0.req_valid = v; rif0.req_data0 = d0; rif0.req_data1 = d1;
        end
    endtask

    // Request a byte, then follow the expected frame bit-for-bit against the baud pulses.
    task automatic run_frame(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                             input bit hold, input int stop_at);
        int         g, sb, k, budget, nb;
        logic [7:0] d;
        logic [1:0] er;
        bit         first;
        logic       bits[$];
        sb = sel ? 2 : 1;
        g  = (v == 2'b11) ? (1 - last_gnt[sel]) : ((v == 2'b10) ? 1 : 0);
        d  = (g == 1) ? d1 : d0;
        er = (g == 1) ? 2'b10 : 2'b01;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^d);
`endif
        for (int i = 0; i < sb; i++) bits.push_back(1'b1);
        nb = bits.size();

        set_req(v, d0, d1);
        budget = 0;
        do begin
            tick();
            budget++;
        end while (s_ready == 2'b00 && budget < 20);
        chk("req_ready", 32'(s_ready), 32'(er));
        chk("tx_start_with_ready", 32'(s_start), 32'd1);
        chk("busy_at_grant", 32'(s_busy), 32'd1);
        chk("gnt_id", 32'(s_gnt), 32'(g));
        last_gnt[sel] = g;
        if (!hold) set_req(2'b00, d0, d1);

        k = 0;
        first = 1'b1;
        budget = 0;
        while (k <= nb && budget < 400) begin
            tick();
            budget++;
            if (first) begin
                chk("ready_one_cycle", 32'(s_ready), 32'd0);
                chk("tx_start_one_cycle", 32'(s_start), 32'd0);
                first = 1'b0;
            end
            if (bps_prev) k++;
            if (stop_at != 0 && k == stop_at) return;
            if (k <= nb) begin
                chk("txd", 32'(s_txd), (k == 0) ? 32'd1 : 32'(bits[k-1]));
                chk("tx_done_quiet", 32'(s_done), 32'd0);
                chk("err_quiet", 32'(s_err), 32'd0);
                chk("busy_frame", 32'(s_busy), 32'd1);
            end
        end
        chk("end_pulse_count", 32'(k), 32'(nb + 1));
        chk("tx_done_end", 32'(s_done), 32'd1);
        chk("busy_end", 32'(s_busy), 32'd0);
        chk("txd_end", 32'(s_txd), 32'd1);
        tick();
        chk("tx_done_one_cycle", 32'(s_done), 32'd0);
    endtask

    initial begin
        int         n;
        logic [1:0] v;
        rst_n = 1'b0;
        bps_clk = 1'b0;
        bps_en = 1'b1;
        bps_cnt = 0;
        bps_prev = 1'b0;
        sel = 1'b0;
        last_gnt[0] = 1;
        last_gnt[1] = 1;
        rif0.req_valid = 2'b00; rif0.req_data0 = 8'h00; rif0.req_data1 = 8'h00;
        rif1.req_valid = 2'b00; rif1.req_data0 = 8'h00; rif1.req_data1 = 8'h00;
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_txd", 32'(s_txd), 32'd1);
            chk("rst_tx_start", 32'(s_start), 32'd0);
            chk("rst_tx_done", 32'(s_done), 32'd0);
            chk("rst_ready", 32'(s_ready), 32'd0);
            chk("rst_busy", 32'(s_busy), 32'd0);
            chk("rst_gnt_id", 32'(s_gnt), 32'd0);
            chk("rst_err", 32'(s_err), 32'd0);
        end
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        sel = 1'b0;
        run_frame(2'b01, 8'hA5, 8'h00, 1'b0, 0);

        sel = 1'b1;
        run_frame(2'b11, 8'h11, 8'h22, 1'b1, 0);
        run_frame(2'b11, 8'h11, 8'h22, 1'b1, 0);
        run_frame(2'b11, 8'h11, 8'h22, 1'b0, 0);

        sel = 1'b0;
        run_frame(2'b01, 8'h07, 8'h00, 1'b0, 0);
        run_frame(2'b10, 8'h00, 8'h03, 1'b0, 0);

        sel = 1'b1;
        run_frame(2'b01, 8'hFF, 8'h00, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            sel = 1'($urandom_range(0, 1));
            v = 2'($urandom_range(1, 3));
            run_frame(v, 8'($urandom), 8'($urandom), 1'b0, 0);
        end

        // Watchdog: baud stops after the third pulse.
        sel = 1'b0;
        run_frame(2'b01, 8'h3C, 8'h00, 1'b0, 3);
        bps_en = 1'b0;
        n = 0;
        while (s_err !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_latency", 32'(n), 32'(TOC));
        chk("timeout_tx_done", 32'(s_done), 32'd1);
        chk("timeout_txd", 32'(s_txd), 32'd1);
        chk("timeout_busy", 32'(s_busy), 32'd0);
        tick();
        chk("timeout_err_one_cycle", 32'(s_err), 32'd0);
        chk("timeout_done_one_cycle", 32'(s_done), 32'd0);
        bps_cnt = 0;
        bps_en = 1'b1;
        run_frame(2'b10, 8'h00, 8'h96, 1'b0, 0);

        // Reset during data bit 4 of 0xA5 (that bit is 0).
        sel = 1'b0;
        run_frame(2'b01, 8'hA5, 8'h00, 1'b0, 6);
        chk("pre_reset_txd", 32'(s_txd), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_txd", 32'(s_txd), 32'd1);
        chk("async_rst_busy", 32'(s_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_tx_done", 32'(s_done), 32'd0);
            chk("rst_no_err", 32'(s_err), 32'd0);
        end
        rst_n = 1'b1;
        last_gnt[0] = 1;
        last_gnt[1] = 1;
        tick();
        run_frame(2'b11, 8'h5A, 8'hC3, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
